// File: rtl/el2_exu_div_receiver_if.sv
// el2_exu_div_receiver_if: NoC down-port flit channel plus divider request/response signals.
interface el2_exu_div_receiver_if #(
  parameter int FLIT_BITS = 16,
  parameter int DP_BITS   = 3
);
  logic                 flit_valid;
  logic [FLIT_BITS-1:0] flit_data;
  logic                 flit_last;
  logic                 flit_ready;
  logic                 noc_sr_flush;
  logic                 div_busy;
  logic [DP_BITS-1:0]   dp_out;
  logic [31:0]          dividend;
  logic [31:0]          divisor;
  logic                 cancel_out;
  logic                 req_valid;
  logic                 frame_err;
  modport slave (
    input  flit_valid, flit_data, flit_last, noc_sr_flush, div_busy,
    output flit_ready, dp_out, dividend, divisor, cancel_out, req_valid, frame_err
  );
  modport master (
    output flit_valid, flit_data, flit_last, noc_sr_flush, div_busy,
    input  flit_ready, dp_out, dividend, divisor, cancel_out, req_valid, frame_err
  );
endinterface

// File: rtl/el2_exu_div_receiver.sv
// el2_exu_div_receiver: reassembles divide-request flits into a one-cycle request for el2_exu_div.
module el2_exu_div_receiver #(
  parameter int FLIT_BITS = 16,
  parameter int DP_BITS   = 3,
  localparam int FRAME_BITS = 64 + DP_BITS + 1,
  localparam int NFLITS     = (FRAME_BITS + FLIT_BITS - 1) / FLIT_BITS
) (
  input logic clk_noc,
  input logic rst_l,
  el2_exu_div_receiver_if.slave bus
);
  localparam int CW = $clog2(NFLITS + 1);
  typedef enum logic [2:0] {IDLE, RECV, DELIVER, HOLD, ERR} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  ready, accept, req, cxl_out, err;
  logic [DP_BITS-1:0]    dp;
  logic                  cxl;
  // Frame is kept right-aligned; leading zero-extension bits of flit 0 shift out the top.
  assign dp     = frame_q[FRAME_BITS-1 -: DP_BITS];
  assign cxl    = frame_q[64];
  assign ready  = rst_l & ~bus.noc_sr_flush & (state_q inside {IDLE, RECV, ERR});
  assign accept = bus.flit_valid & ready;
  assign frame_d = accept ? {frame_q[FRAME_BITS-FLIT_BITS-1:0], bus.flit_data} : frame_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    cxl_out = 1'b0;
    err     = 1'b0;
    if (bus.noc_sr_flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, ERR: begin
          err     = state_q == ERR;
          cnt_d   = accept ? CW'(1) : cnt_q;
          state_d = accept ? (bus.flit_last ? ERR : RECV) : IDLE;
        end
        RECV: begin
          cnt_d   = accept ? cnt_q + 1'b1 : cnt_q;
          state_d = !accept ? RECV :
                    (cnt_q == CW'(NFLITS - 1)) ? (bus.flit_last ? DELIVER : ERR) :
                    (bus.flit_last ? ERR : RECV);
        end
        DELIVER: begin
          cxl_out = cxl;
          req     = cxl ? dp[DP_BITS-1] & ~bus.div_busy : ~bus.div_busy;
          state_d = (!cxl && bus.div_busy) ? HOLD : IDLE;
        end
        HOLD: begin
          req     = ~bus.div_busy;
          state_d = bus.div_busy ? HOLD : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_noc or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end
  assign bus.flit_ready = ready;
  assign bus.req_valid  = req;
  assign bus.cancel_out = cxl_out;
  assign bus.frame_err  = err;
  assign bus.dp_out     = {dp[DP_BITS-1] & req, dp[DP_BITS-2:0]};
  assign bus.dividend   = frame_q[63:32];
  assign bus.divisor    = frame_q[31:0];
endmodule

// File: tb/tb_el2_exu_div_receiver.sv
// tb_el2_exu_div_receiver: directed and random frames checked against a queue-based frame model.
module tb_el2_exu_div_receiver;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic rnd = 1'b0;
  int checks = 0;
  int errors = 0;
  el2_exu_div_receiver_if ifc ();
  el2_exu_div_receiver dut (.clk_noc(clk), .rst_l(rst_l), .bus(ifc));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input bit l);
    int t = 0;
    ifc.flit_valid = 1'b1;
    ifc.flit_data  = d;
    ifc.flit_last  = l;
    @(negedge clk);
    while (!ifc.flit_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 32'(t), 32'(0));
    step();
    ifc.flit_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] f0, input logic [31:0] a, input logic [31:0] b);
    send(f0, 0);
    send(a[31:16], 0);
    send(a[15:0], 0);
    send(b[31:16], 0);
    send(b[15:0], 1);
  endtask

  // Reference model: partial frame as a flit queue, one pending request, one pending error.
  logic [15:0] q[$];
  bit          pend;
  bit          errn;
  logic [79:0] pf;
  initial begin
    bit e_ready, e_req, e_cxl, e_err;
    pend = 0;
    errn = 0;
    pf   = '0;
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        chk("rst_ready", 32'(ifc.flit_ready), 0);
        chk("rst_req", 32'(ifc.req_valid), 0);
        chk("rst_cancel", 32'(ifc.cancel_out), 0);
        chk("rst_err", 32'(ifc.frame_err), 0);
        chk("rst_dp", 32'(ifc.dp_out), 0);
        chk("rst_dividend", ifc.dividend, 0);
        chk("rst_divisor", ifc.divisor, 0);
        q.delete();
        pend = 0;
        errn = 0;
        continue;
      end
      e_ready = !ifc.noc_sr_flush && !pend;
      e_req = 0;
      e_cxl = 0;
      e_err = 0;
      if (!ifc.noc_sr_flush) begin
        e_err = errn;
        if (pend) begin
          e_cxl = pf[64];
          e_req = pf[64] ? pf[67] && !ifc.div_busy : !ifc.div_busy;
        end
      end
      chk("ready", 32'(ifc.flit_ready), 32'(e_ready));
      chk("req_valid", 32'(ifc.req_valid), 32'(e_req));
      chk("cancel_out", 32'(ifc.cancel_out), 32'(e_cxl));
      chk("frame_err", 32'(ifc.frame_err), 32'(e_err));
      if (e_req) begin
        chk("dp_out", 32'(ifc.dp_out), 32'(pf[67:65]));
        chk("dividend", ifc.dividend, pf[63:32]);
        chk("divisor", ifc.divisor, pf[31:0]);
      end else chk("dp_valid_idle", 32'(ifc.dp_out[2]), 0);
      errn = 0;
      if (ifc.noc_sr_flush) begin
        q.delete();
        pend = 0;
      end else begin
        if (pend && (pf[64] || !ifc.div_busy)) pend = 0;
        if (e_ready && ifc.flit_valid) begin
          q.push_back(ifc.flit_data);
          if (ifc.flit_last || q.size() == 5) begin
            if (ifc.flit_last && q.size() == 5) begin
              pend = 1;
              pf = {q[0], q[1], q[2], q[3], q[4]};
            end else errn = 1;
            q.delete();
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd) begin
      ifc.div_busy     = 1'($urandom % 2);
      ifc.noc_sr_flush = ($urandom % 40) == 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.flit_valid = 0;
    ifc.flit_data = 0;
    ifc.flit_last = 0;
    ifc.noc_sr_flush = 0;
    ifc.div_busy = 0;
    repeat (3) begin
      step();
      ifc.flit_valid = 1;
      ifc.flit_data = 16'($urandom);
      ifc.flit_last = 1'($urandom);
      @(negedge clk);
      chk("lit_rst_ready", 32'(ifc.flit_ready), 0);
    end
    step();
    rst_l = 1;
    ifc.flit_valid = 0;
    @(negedge clk);
    chk("lit_ready_after_rst", 32'(ifc.flit_ready), 1);
    step();
    send_frame(16'h000C, 32'd100, 32'd7);
    @(negedge clk);
    chk("lit_nom_req", 32'(ifc.req_valid), 1);
    chk("lit_nom_dp", 32'(ifc.dp_out), 32'b110);
    chk("lit_nom_dividend", ifc.dividend, 100);
    chk("lit_nom_divisor", ifc.divisor, 7);
    chk("lit_nom_cancel", 32'(ifc.cancel_out), 0);
    step();
    ifc.div_busy = 1;
    send_frame(16'h000C, 32'd100, 32'd7);
    ifc.flit_valid = 1;
    ifc.flit_data = 16'h0001;
    ifc.flit_last = 0;
    repeat (4) begin
      @(negedge clk);
      chk("lit_hold_req", 32'(ifc.req_valid), 0);
      chk("lit_hold_ready", 32'(ifc.flit_ready), 0);
      step();
    end
    ifc.div_busy = 0;
    @(negedge clk);
    chk("lit_hold_release", 32'(ifc.req_valid), 1);
    chk("lit_hold_dp", 32'(ifc.dp_out), 32'b110);
    step();
    ifc.div_busy = 1;
    @(negedge clk);
    chk("lit_hold_idle_ready", 32'(ifc.flit_ready), 1);
    step();
    send(0, 0);
    send(0, 0);
    send(0, 0);
    send(0, 1);
    @(negedge clk);
    chk("lit_cxl_pulse", 32'(ifc.cancel_out), 1);
    chk("lit_cxl_req", 32'(ifc.req_valid), 0);
    step();
    @(negedge clk);
    chk("lit_cxl_once", 32'(ifc.cancel_out), 0);
    chk("lit_cxl_nohold", 32'(ifc.flit_ready), 1);
    step();
    ifc.div_busy = 0;
    send(16'h1111, 0);
    send(16'h2222, 0);
    send(16'h3333, 1);
    @(negedge clk);
    chk("lit_bad_err", 32'(ifc.frame_err), 1);
    chk("lit_bad_req", 32'(ifc.req_valid), 0);
    step();
    send_frame(16'h0008, 32'hFFFF_FFF6, 32'd3);
    @(negedge clk);
    chk("lit_neg_req", 32'(ifc.req_valid), 1);
    chk("lit_neg_dp", 32'(ifc.dp_out), 32'b100);
    chk("lit_neg_dividend", ifc.dividend, 32'hFFFF_FFF6);
    chk("lit_neg_divisor", ifc.divisor, 3);
    step();
    send(16'h1234, 0);
    send(16'h5678, 0);
    ifc.noc_sr_flush = 1;
    ifc.flit_valid = 1;
    ifc.flit_data = 16'h9999;
    @(negedge clk);
    chk("lit_flush_ready", 32'(ifc.flit_ready), 0);
    chk("lit_flush_req", 32'(ifc.req_valid), 0);
    step();
    ifc.noc_sr_flush = 0;
    ifc.flit_valid = 0;
    send_frame(16'h000C, 32'd5, 32'd2);
    @(negedge clk);
    chk("lit_flush_next_req", 32'(ifc.req_valid), 1);
    chk("lit_flush_dividend", ifc.dividend, 5);
    chk("lit_flush_divisor", ifc.divisor, 2);
    step();
    send(16'h000C, 0);
    send(16'h0001, 0);
    rst_l = 0;
    @(negedge clk);
    chk("lit_midrst_ready", 32'(ifc.flit_ready), 0);
    step();
    rst_l = 1;
    send_frame(16'h000E, 32'd9, 32'd3);
    @(negedge clk);
    chk("lit_midrst_req", 32'(ifc.req_valid), 1);
    chk("lit_midrst_dp", 32'(ifc.dp_out), 32'b111);
    chk("lit_midrst_dividend", ifc.dividend, 9);
    step();
    rnd = 1;
    for (int f = 0; f < 300; f++) begin
      int len;
      len = ($urandom % 8 == 0) ? int'($urandom_range(1, 6)) : 5;
      for (int i = 0; i < len; i++) begin
        repeat ($urandom % 3) step();
        send(16'($urandom), i == len - 1);
      end
    end
    rnd = 0;
    step();
    ifc.noc_sr_flush = 0;
    ifc.div_busy = 0;
    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
